// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: datapath width and the
// layout of the 10-bit control bundle carried from ID into EX.
package mips_pkg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 10;

  // Control bundle {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, RegDst, ALUOp[3:0]}
  localparam int CTRL_REGWRITE  = 9;
  localparam int CTRL_MEMTOREG  = 8;
  localparam int CTRL_MEMREAD   = 7;
  localparam int CTRL_MEMWRITE  = 6;
  localparam int CTRL_ALUSRC    = 5;
  localparam int CTRL_REGDST    = 4;
  localparam int CTRL_ALUOP_MSB = 3;
  localparam int CTRL_ALUOP_LSB = 0;

  // A bubble carries no side effects: every control bit cleared.
  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_hazard.sv
// Load-use hazard detection for the ID stage. Purely combinational:
// stalls ID when the instruction in EX is a load whose destination is
// read by the instruction in ID. A taken branch/jump suppresses the stall
// because the ID instruction is being killed anyway.
module id_hazard_unit
  import mips_pkg::*;
(
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_dst,
  input  logic       flush,
  output logic       stall_id
);

  logic hz;

  // rt is compared unconditionally; I-type instructions may stall spuriously.
  always_comb begin
    hz = id_valid && ex_valid && ex_mem_read && (ex_dst != 5'd0) &&
         ((ex_dst == id_rs) || (ex_dst == id_rt));
    stall_id = hz && !flush;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX boundary: write-back bypass on the register-file read data,
// destination resolution, load-use stall, the ID/EX pipeline register
// with bubble insertion, and saturating stall/flush debug counters.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic                        clock,
  input  logic                        Regreset,
  input  logic                        id_valid,
  input  logic [4:0]                  id_rs,
  input  logic [4:0]                  id_rt,
  input  logic [4:0]                  id_rd,
  input  logic [XLEN-1:0]             id_imm,
  input  logic [mips_pkg::CTRL_W-1:0] id_ctrl,
  input  logic [XLEN-1:0]             rf_rd1,
  input  logic [XLEN-1:0]             rf_rd2,
  input  logic                        wb_we,
  input  logic [4:0]                  wb_addr,
  input  logic [XLEN-1:0]             wb_data,
  input  logic                        flush,
  output logic                        stall_id,
  output logic                        ex_valid,
  output logic [mips_pkg::CTRL_W-1:0] ex_ctrl,
  output logic [XLEN-1:0]             ex_a,
  output logic [XLEN-1:0]             ex_b,
  output logic [XLEN-1:0]             ex_imm,
  output logic [4:0]                  ex_rs,
  output logic [4:0]                  ex_rt,
  output logic [4:0]                  ex_dst,
  output logic [CNT_W-1:0]            stall_count,
  output logic [CNT_W-1:0]            flush_count
);

  import mips_pkg::*;

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      dst;
  logic            bubble;

  id_hazard_unit u_hazard (
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl[CTRL_MEMREAD]),
    .ex_dst      (ex_dst),
    .flush       (flush),
    .stall_id    (stall_id)
  );

  // Bypass the value being written back this cycle: the register file only
  // commits it on the same edge that ID/EX captures. r0 never bypasses.
  always_comb begin
    op_a = rf_rd1;
    op_b = rf_rd2;
    if (wb_we && (wb_addr != 5'd0) && (wb_addr == id_rs)) op_a = wb_data;
    if (wb_we && (wb_addr != 5'd0) && (wb_addr == id_rt)) op_b = wb_data;
  end

  // Resolve destination; non-writing instructions target r0 so they never
  // trigger hazards or forwarding downstream.
  always_comb begin
    dst = id_ctrl[CTRL_REGDST] ? id_rd : id_rt;
    if (!id_ctrl[CTRL_REGWRITE]) dst = 5'd0;
    // flush and load-use both produce a bubble; stall_id is hz masked by flush
    bubble = flush || stall_id;
  end

  // ID/EX pipeline register: reset > bubble (flush or hazard) > capture.
  always_ff @(posedge clock or posedge Regreset) begin
    if (Regreset) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= CTRL_BUBBLE;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_imm   <= '0;
      ex_rs    <= 5'd0;
      ex_rt    <= 5'd0;
      ex_dst   <= 5'd0;
    end else if (bubble) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= CTRL_BUBBLE;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_imm   <= '0;
      ex_rs    <= 5'd0;
      ex_rt    <= 5'd0;
      ex_dst   <= 5'd0;
    end else begin
      ex_valid <= id_valid;
      ex_ctrl  <= id_valid ? id_ctrl : CTRL_BUBBLE;
      ex_a     <= op_a;
      ex_b     <= op_b;
      ex_imm   <= id_imm;
      ex_rs    <= id_rs;
      ex_rt    <= id_rt;
      ex_dst   <= dst;
    end
  end

  // Saturating debug counters for stall cycles and killed valid instructions.
  always_ff @(posedge clock or posedge Regreset) begin
    if (Regreset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_id && (stall_count != '1)) stall_count <= stall_count + 1'b1;
      if (flush && id_valid && (flush_count != '1)) flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, hand sequences for the
// multi-cycle cases, and a randomized run against a register-file level
// reference model. A second instance with 4-bit counters exercises saturation.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm;
    logic [9:0]  ctrl;
    logic [31:0] rd1, rd2;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
  } id_in_t;

  typedef struct packed {
    id_in_t      in;
    logic        valid;
    logic [9:0]  ctrl;
    logic [31:0] a, b;
    logic [4:0]  dst;
  } vec_t;

  typedef struct packed {
    logic        valid;
    logic [9:0]  ctrl;
    logic [31:0] a, b, imm;
    logic [4:0]  rs, rt, dst;
  } ex_m_t;

  localparam logic [9:0] C_ADD = 10'h210;  // RegWrite, RegDst
  localparam logic [9:0] C_LW  = 10'h3A0;  // RegWrite, MemtoReg, MemRead, ALUSrc

  logic clock = 1'b0;
  logic Regreset = 1'b1;
  logic id_valid, wb_we, flush;
  logic [4:0] id_rs, id_rt, id_rd, wb_addr;
  logic [31:0] id_imm, rf_rd1, rf_rd2, wb_data;
  logic [9:0] id_ctrl;

  logic stall_id, ex_valid;
  logic [9:0] ex_ctrl;
  logic [31:0] ex_a, ex_b, ex_imm;
  logic [4:0] ex_rs, ex_rt, ex_dst;
  logic [15:0] stall_count, flush_count;

  logic s_stall_id, s_ex_valid;
  logic [9:0] s_ex_ctrl;
  logic [31:0] s_ex_a, s_ex_b, s_ex_imm;
  logic [4:0] s_ex_rs, s_ex_rt, s_ex_dst;
  logic [3:0] s_stall_count, s_flush_count;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clock(clock), .Regreset(Regreset), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .stall_id(stall_id), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_dst(ex_dst), .stall_count(stall_count), .flush_count(flush_count));

  id_ex_stage #(.XLEN(32), .CNT_W(4)) dut_s (
    .clock(clock), .Regreset(Regreset), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .stall_id(s_stall_id), .ex_valid(s_ex_valid), .ex_ctrl(s_ex_ctrl),
    .ex_a(s_ex_a), .ex_b(s_ex_b), .ex_imm(s_ex_imm), .ex_rs(s_ex_rs), .ex_rt(s_ex_rt),
    .ex_dst(s_ex_dst), .stall_count(s_stall_count), .flush_count(s_flush_count));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic id_in_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [31:0] imm,
                                input logic [9:0] ctrl, input logic [31:0] rd1,
                                input logic [31:0] rd2, input logic we,
                                input logic [4:0] wa, input logic [31:0] wd, input logic fl);
    id_in_t r;
    r.valid = v; r.rs = rs; r.rt = rt; r.rd = rd; r.imm = imm; r.ctrl = ctrl;
    r.rd1 = rd1; r.rd2 = rd2; r.wb_we = we; r.wb_addr = wa; r.wb_data = wd; r.flush = fl;
    return r;
  endfunction

  function automatic logic [63:0] sat(input int n, input int w);
    int top;
    top = (1 << w) - 1;
    return (n >= top) ? 64'(top) : 64'(n);
  endfunction

  task automatic drive(input id_in_t v);
    id_valid = v.valid; id_rs = v.rs; id_rt = v.rt; id_rd = v.rd; id_imm = v.imm;
    id_ctrl = v.ctrl; rf_rd1 = v.rd1; rf_rd2 = v.rd2; wb_we = v.wb_we;
    wb_addr = v.wb_addr; wb_data = v.wb_data; flush = v.flush;
  endtask

  // Present ID inputs mid-cycle, then settle.
  task automatic step(input id_in_t v);
    @(negedge clock);
    drive(v);
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ex_valid"}, ex_valid, 0);
    check({tag, ".ex_ctrl"}, ex_ctrl, 0);
    check({tag, ".ex_a"}, ex_a, 0);
    check({tag, ".ex_b"}, ex_b, 0);
    check({tag, ".ex_imm"}, ex_imm, 0);
    check({tag, ".ex_rs"}, ex_rs, 0);
    check({tag, ".ex_rt"}, ex_rt, 0);
    check({tag, ".ex_dst"}, ex_dst, 0);
    check({tag, ".stall_id"}, stall_id, 0);
    check({tag, ".stall_count"}, stall_count, 0);
    check({tag, ".flush_count"}, flush_count, 0);
    check({tag, ".s_stall_count"}, s_stall_count, 0);
    check({tag, ".s_flush_count"}, s_flush_count, 0);
  endtask

  // Assert reset between edges and confirm it takes effect without a clock.
  task automatic do_reset(input string tag);
    @(negedge clock);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2 Regreset = 1'b1;
    #1 check_all_zero(tag);
    @(negedge clock);
    Regreset = 1'b0;
  endtask

  vec_t vecs[6];
  id_in_t cur;
  ex_m_t m;
  logic [31:0] regs [32];
  int stall_m, flush_m;
  bit held, hz, exp_stall;

  initial begin
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1 check_all_zero("por");
    @(negedge clock);
    Regreset = 1'b0;

    // ---------- directed vector table (no loads, so no hazards between rows)
    vecs[0] = '{mk(1, 5, 6, 12, 32'h4, C_ADD, 32'h11, 32'h22, 1, 5, 32'hDEADBEEF, 0),
                1, C_ADD, 32'hDEADBEEF, 32'h22, 5'd12};
    vecs[1] = '{mk(1, 5, 6, 12, 32'h4, C_ADD, 32'h11, 32'h22, 1, 0, 32'hDEADBEEF, 0),
                1, C_ADD, 32'h11, 32'h22, 5'd12};
    vecs[2] = '{mk(1, 0, 0, 12, 32'h8, 10'h010, 32'h0, 32'h0, 1, 0, 32'hCAFE, 0),
                1, 10'h010, 32'h0, 32'h0, 5'd0};
    vecs[3] = '{mk(1, 3, 7, 9, 32'hFFFFFFF0, 10'h221, 32'h33, 32'h44, 1, 7, 32'h1234, 0),
                1, 10'h221, 32'h33, 32'h1234, 5'd7};
    vecs[4] = '{mk(1, 3, 4, 1, 32'h0, C_ADD, 32'h55, 32'h66, 0, 3, 32'h99, 0),
                1, C_ADD, 32'h55, 32'h66, 5'd1};
    vecs[5] = '{mk(0, 2, 3, 4, 32'h77, C_ADD, 32'hA, 32'hB, 0, 0, 0, 0),
                0, 10'h000, 32'hA, 32'hB, 5'd4};
    for (int i = 0; i < 6; i++) begin
      step(vecs[i].in);
      check($sformatf("vec%0d.stall_id", i), stall_id, 0);
      tick();
      check($sformatf("vec%0d.ex_valid", i), ex_valid, vecs[i].valid);
      check($sformatf("vec%0d.ex_ctrl", i), ex_ctrl, vecs[i].ctrl);
      check($sformatf("vec%0d.ex_a", i), ex_a, vecs[i].a);
      check($sformatf("vec%0d.ex_b", i), ex_b, vecs[i].b);
      check($sformatf("vec%0d.ex_imm", i), ex_imm, vecs[i].in.imm);
      check($sformatf("vec%0d.ex_rs", i), ex_rs, vecs[i].in.rs);
      check($sformatf("vec%0d.ex_rt", i), ex_rt, vecs[i].in.rt);
      check($sformatf("vec%0d.ex_dst", i), ex_dst, vecs[i].dst);
    end

    // ---------- load-use: one-cycle stall, bubble, then the add is captured
    do_reset("rst_lu");
    step(mk(1, 1, 8, 0, 32'h10, C_LW, 32'h100, 0, 0, 0, 0, 0));
    tick();
    check("lu.lw_dst", ex_dst, 8);
    step(mk(1, 8, 2, 3, 0, C_ADD, 32'h5, 32'h6, 0, 0, 0, 0));
    check("lu.stall", stall_id, 1);
    tick();
    check("lu.bubble_valid", ex_valid, 0);
    check("lu.bubble_ctrl", ex_ctrl, 0);
    check("lu.bubble_dst", ex_dst, 0);
    check("lu.stall_count1", stall_count, 1);
    step(mk(1, 8, 2, 3, 0, C_ADD, 32'h5, 32'h6, 0, 0, 0, 0));
    check("lu.no_second_stall", stall_id, 0);
    tick();
    check("lu.add_valid", ex_valid, 1);
    check("lu.add_rs", ex_rs, 8);
    check("lu.add_dst", ex_dst, 3);
    check("lu.stall_count_hold", stall_count, 1);

    // ---------- flush beats stall
    do_reset("rst_fl");
    step(mk(1, 1, 8, 0, 0, C_LW, 0, 0, 0, 0, 0, 0));
    tick();
    step(mk(1, 8, 2, 3, 0, C_ADD, 32'h5, 32'h6, 0, 0, 0, 1));
    check("fl.stall_suppressed", stall_id, 0);
    tick();
    check("fl.bubble_valid", ex_valid, 0);
    check("fl.bubble_a", ex_a, 0);
    check("fl.flush_count", flush_count, 1);
    check("fl.stall_count", stall_count, 0);

    // ---------- non-writing load resolves to r0 and never stalls
    step(mk(1, 1, 9, 0, 0, 10'h1A0, 0, 0, 0, 0, 0, 0));
    tick();
    check("r0.dst_regwrite0", ex_dst, 0);
    step(mk(1, 1, 0, 0, 0, C_LW, 0, 0, 0, 0, 0, 0));
    tick();
    check("r0.lw_r0_dst", ex_dst, 0);
    step(mk(1, 0, 0, 4, 0, C_ADD, 0, 0, 0, 0, 0, 0));
    check("r0.no_stall", stall_id, 0);
    tick();

    // ---------- saturation (4-bit instance) with 20 stalls and 20 flushes
    do_reset("rst_sat");
    for (int i = 0; i < 20; i++) begin
      step(mk(1, 1, 8, 0, 0, C_LW, 0, 0, 0, 0, 0, 0));
      tick();
      step(mk(1, 8, 2, 3, 0, C_ADD, 0, 0, 0, 0, 0, 0));
      tick();
    end
    check("sat.stall_count_small", s_stall_count, 4'hF);
    check("sat.stall_count_wide", stall_count, 20);
    for (int i = 0; i < 20; i++) begin
      step(mk(1, 1, 2, 3, 0, C_ADD, 0, 0, 0, 0, 0, 1));
      tick();
    end
    check("sat.flush_count_small", s_flush_count, 4'hF);
    check("sat.flush_count_wide", flush_count, 20);

    // ---------- randomized run against a register-file level model
    do_reset("rst_rand");
    m = '0;
    stall_m = 0;
    flush_m = 0;
    held = 0;
    for (int r = 0; r < 32; r++) regs[r] = 32'h0;
    cur = '0;
    for (int c = 0; c < 2000; c++) begin
      if (!held) begin
        cur.valid = ($urandom_range(0, 9) != 0);
        cur.rs    = 5'($urandom_range(0, 3));
        cur.rt    = 5'($urandom_range(0, 3));
        cur.rd    = 5'($urandom_range(0, 3));
        cur.imm   = $urandom;
        cur.ctrl  = 10'($urandom);
      end
      cur.wb_we   = 1'($urandom);
      cur.wb_addr = 5'($urandom_range(0, 3));
      cur.wb_data = $urandom;
      cur.flush   = ($urandom_range(0, 7) == 0);
      cur.rd1     = regs[cur.rs];
      cur.rd2     = regs[cur.rt];
      step(cur);

      hz = cur.valid && m.valid && m.ctrl[7] && (m.dst != 0) &&
           ((m.dst == cur.rs) || (m.dst == cur.rt));
      exp_stall = hz && !cur.flush;
      check("rnd.stall_id", stall_id, exp_stall);

      // architectural state after this edge's write-back
      if (cur.wb_we && cur.wb_addr != 0) regs[cur.wb_addr] = cur.wb_data;
      if (cur.flush || hz) begin
        m = '0;
      end else begin
        m.valid = cur.valid;
        m.ctrl  = cur.valid ? cur.ctrl : 10'h0;
        m.a     = regs[cur.rs];
        m.b     = regs[cur.rt];
        m.imm   = cur.imm;
        m.rs    = cur.rs;
        m.rt    = cur.rt;
        m.dst   = cur.ctrl[9] ? (cur.ctrl[4] ? cur.rd : cur.rt) : 5'd0;
      end
      if (exp_stall) stall_m++;
      if (cur.flush && cur.valid) flush_m++;
      held = exp_stall;

      tick();
      check("rnd.ex_valid", ex_valid, m.valid);
      check("rnd.ex_ctrl", ex_ctrl, m.ctrl);
      check("rnd.ex_a", ex_a, m.a);
      check("rnd.ex_b", ex_b, m.b);
      check("rnd.ex_imm", ex_imm, m.imm);
      check("rnd.ex_rs", ex_rs, m.rs);
      check("rnd.ex_rt", ex_rt, m.rt);
      check("rnd.ex_dst", ex_dst, m.dst);
      check("rnd.stall_count", stall_count, sat(stall_m, 16));
      check("rnd.flush_count", flush_count, sat(flush_m, 16));
      check("rnd.s_stall_count", s_stall_count, sat(stall_m, 4));
      check("rnd.s_flush_count", s_flush_count, sat(flush_m, 4));
    end

    // ---------- reset mid-run with a live instruction in EX
    step(mk(1, 0, 0, 6, 32'h1, C_ADD, 0, 0, 0, 0, 0, 0));
    tick();
    check("mid.ex_valid_before", ex_valid, 1);
    do_reset("rst_mid");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
